// File: rtl/dmem_ctrl.sv
// Two-port round-robin controller for an async-read / sync-write word memory.
// Sub-word loads are lane-extracted; sub-word stores use read-modify-write.
// Defining DMEM_CHECK_EN enables the alignment and range error checks.
module dmem_ctrl #(
  parameter int unsigned MEM_BYTES      = 4096,
  parameter bit          RST_LAST_GRANT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

  state_t          state_q, state_d;
  logic            we_q, uns_q, port_q, last_grant_q;
  logic [1:0]      size_q;
  logic [DW-1:0]   addr_q, wdata_q, merge_q, rdata0_q, rdata1_q;
  logic            grant_c, gnt_port_c, err_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [DW-1:0]   load_c, merge_c, word_addr_c;

  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign word_addr_c = {addr_q[31:2], 2'b00};

  // On a tie the port that was not served last wins
  assign gnt_port_c = (m0_req && m1_req) ? ~last_grant_q : m1_req;

`ifdef DMEM_CHECK_EN
  always_comb begin
    err_c = 1'b0;
    if (size_q == 2'b01 && addr_q[0])          err_c = 1'b1;
    if (size_q[1] && addr_q[1:0] != 2'b00)     err_c = 1'b1;
    if (addr_q >= DW'(MEM_BYTES))              err_c = 1'b1;
  end
`else
  assign err_c = 1'b0;
`endif

  // Lane extraction with sign/zero extension
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_c = mem_read_data[7:0];
      2'd1:    byte_c = mem_read_data[15:8];
      2'd2:    byte_c = mem_read_data[23:16];
      default: byte_c = mem_read_data[31:24];
    endcase
    half_c = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_q)
      2'b00:   load_c = uns_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_c = uns_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_c = mem_read_data;
    endcase
  end

  // Substitute the stored lane(s) into the word just read
  always_comb begin
    merge_c = mem_read_data;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_c[31:16] = wdata_q[15:0];
    end else begin
      merge_c[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus state-decoded memory and response strobes
  always_comb begin
    state_d        = state_q;
    grant_c        = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    m0_ack         = 1'b0;
    m1_ack         = 1'b0;
    m0_err         = 1'b0;
    m1_err         = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_c = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_address = word_addr_c;
        state_d     = RESP;
        if (!err_c) begin
          if (!we_q) begin
            mem_read_en = 1'b1;
          end else if (size_q[1]) begin
            mem_write_en   = 1'b1;
            mem_write_data = wdata_q;
          end else begin
            mem_read_en = 1'b1;
            state_d     = MERGE_WR;
          end
        end
      end
      MERGE_WR: begin
        mem_address    = word_addr_c;
        mem_write_en   = 1'b1;
        mem_write_data = merge_q;
        state_d        = RESP;
      end
      RESP: begin
        m0_ack  = ~port_q;
        m1_ack  = port_q;
        m0_err  = ~port_q & err_c;
        m1_err  = port_q & err_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      port_q       <= 1'b0;
      last_grant_q <= RST_LAST_GRANT;
      merge_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (grant_c) begin
        we_q         <= gnt_port_c ? m1_we       : m0_we;
        uns_q        <= gnt_port_c ? m1_unsigned : m0_unsigned;
        size_q       <= gnt_port_c ? m1_size     : m0_size;
        addr_q       <= gnt_port_c ? m1_addr     : m0_addr;
        wdata_q      <= gnt_port_c ? m1_wdata    : m0_wdata;
        port_q       <= gnt_port_c;
        last_grant_q <= gnt_port_c;
      end
      if (state_q == ACCESS && !err_c && !we_q) begin
        if (port_q) rdata1_q <= load_c;
        else        rdata0_q <= load_c;
      end
      if (state_q == ACCESS && !err_c && we_q && !size_q[1])
        merge_q <= merge_c;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a 4 KiB word memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_unsigned, m0_ack, m0_err;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_unsigned, m1_ack, m1_err;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write_en) mem[mem_address[11:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[11:2]];

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit p, input bit req, input bit we, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      m1_req = req; m1_we = we; m1_size = sz; m1_unsigned = uns; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = a; m0_wdata = wd;
    end
  endtask

  // One transaction on port p; latency counted in cycles from the IDLE cycle with req high
  task automatic txn(input bit p, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int lat, output bit er,
                     output bit en_seen, output bit bad_side);
    bit got;
    @(negedge clk);
    set_port(p, 1'b1, we, sz, uns, a, wd);
    lat = 0; en_seen = 1'b0; bad_side = 1'b0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_read_en || mem_write_en) en_seen = 1'b1;
      if (mem_read_en && mem_write_en) bad_side = 1'b1;
      if (p ? m0_ack : m1_ack) bad_side = 1'b1;
      got = p ? m1_ack : m0_ack;
    end
    rd = p ? m1_rdata : m0_rdata;
    er = p ? m1_err : m0_err;
    set_port(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] rd;
  int          lat, n;
  bit          er, en, side, both_ack, multi, prev_ack;
  bit          order [0:2];

  initial begin
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_ack", {30'd0, m1_ack, m0_ack}, 32'h0);
    chk("rst_err", {30'd0, m1_err, m0_err}, 32'h0);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    chk("rst_mem_en", {30'd0, mem_write_en, mem_read_en}, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    rst = 1'b0;

    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, lat, er, en, side);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, lat, er, en, side);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_data", rd, 32'hDEADBEEF);
    chk("wld_err", {31'd0, er}, 32'h0);
    chk("wld_side", {31'd0, side}, 32'h0);

    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, lat, er, en, side);
    txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, rd, lat, er, en, side);
    chk("bst_lat", 32'(lat), 32'd3);
    chk("bst_side", {31'd0, side}, 32'h0);
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, lat, er, en, side);
    chk("bst_readback", rd, 32'h1122AA44);

    // Tie: last grant was m1, so m0, m1, m0
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    n = 0; both_ack = 1'b0; multi = 1'b0; prev_ack = 1'b0;
    order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both_ack = 1'b1;
      if ((m0_ack || m1_ack) && prev_ack) multi = 1'b1;
      prev_ack = m0_ack || m1_ack;
      if (m0_ack) begin
        order[n] = 1'b0; n++;
        if (n == 3) m0_req = 1'b0;
      end else if (m1_ack) begin
        order[n] = 1'b1; n++;
        m1_req = 1'b0;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("arb_count", 32'(n), 32'd3);
    chk("arb_order", {29'd0, order[0], order[1], order[2]}, 32'h2);
    chk("arb_both_ack", {31'd0, both_ack}, 32'h0);
    chk("arb_pulse", {31'd0, multi}, 32'h0);
    chk("arb_rdata0", m0_rdata, 32'hDEADBEEF);
    chk("arb_rdata1", m1_rdata, 32'h1122AA44);

    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, rd, lat, er, en, side);
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, rd, lat, er, en, side);
    chk("lb_31", rd, 32'h0000007F);
    txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, rd, lat, er, en, side);
    chk("lb_33", rd, 32'hFFFFFF80);
    txn(1'b0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, rd, lat, er, en, side);
    chk("lhu_32", rd, 32'h000080FF);
    txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, rd, lat, er, en, side);
    chk("lh_32", rd, 32'hFFFF80FF);
    chk("lh_lat", 32'(lat), 32'd2);

    // Reset during MERGE_WR must cancel the write
    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h00000000, rd, lat, er, en, side);
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h00000055);
    @(negedge clk);
    chk("rmw_read_en", {31'd0, mem_read_en}, 32'h1);
    @(negedge clk);
    chk("rmw_write_en", {31'd0, mem_write_en}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", {31'd0, mem_write_en}, 32'h0);
    chk("rst_mid_outs", {28'd0, m1_ack, m0_ack, mem_write_en, mem_read_en}, 32'h0);
    chk("rst_mid_addr", mem_address, 32'h0);
    chk("rst_mid_rdata0", m0_rdata, 32'h0);
    set_port(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem", mem[16], 32'h0);
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, lat, er, en, side);
    chk("rst_mid_readback", rd, 32'h0);

    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D, rd, lat, er, en, side);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, lat, er, en, side);
    chk("al_load", rd, 32'hCAFEF00D);
`ifdef DMEM_CHECK_EN
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, lat, er, en, side);
    chk("mis_err", {31'd0, er}, 32'h1);
    chk("mis_en", {31'd0, en}, 32'h0);
    chk("mis_rdata", rd, 32'hCAFEF00D);
    txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, rd, lat, er, en, side);
    chk("oor_err", {31'd0, er}, 32'h1);
    chk("oor_en", {31'd0, en}, 32'h0);
    chk("oor_rdata", rd, 32'hCAFEF00D);
    chk("oor_lat", 32'(lat), 32'd2);
`else
    txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, lat, er, en, side);
    chk("mis_load", rd, 32'hCAFEF00D);
    chk("mis_err", {31'd0, er}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
